controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Parametrised multicycle control unit for the 16-bit processor.
- Owns the PC and instruction register (IR), and handshakes with instruction memory.
- Sequences FETCH -> DECODE -> EXECUTE -> WRITEBACK and drives the register bank, sign/const extender, ULA operand mux and ULA opcode.
- Adds over the previous controller: single-step or free-run mode, memory ready handshake, fetch timeout, illegal-instruction flag, exactly-one-cycle write enable.

Parameters:
- PC_W, 8, width of program counter / instruction address.
- REG_W, 3, register select width (instruction fields [5:3], [2:0] use the low REG_W bits).
- FETCH_TIMEOUT, 15, max cycles waiting for imem_valid before abort.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while 0.
- run_mode  in  1  1 = free run, 0 = single-step on botao.
- botao  in  1  asynchronous step button.
- imem_req  out  1  instruction read request.
- imem_addr  out  PC_W  instruction address (= pc).
- imem_valid  in  1  instruction data valid.
- imem_data  in  16  instruction word.
- br_we  out  1  register bank write enable.
- br_sel_a  out  REG_W  operand A / destination select.
- br_sel_b  out  REG_W  operand B select.
- ext_ctrl  out  2  extender mode: 00 const11, 01 lcl, 10 lch.
- ext_const  out  11  constant field to extender.
- mux_ula_sel  out  1  0 = BR operand B, 1 = extender.
- ula_op  out  5  ULA operation code.
- estado  out  3  current state encoding.
- illegal  out  1  one-cycle pulse on class-00 instruction.
- fetch_err  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- Reset values: state IDLE, pc=0, IR=0, every output 0, timeout counter 0.
- botao passes through a 2-flop synchroniser plus rising-edge detect, producing step_pulse.
- States (package encoding): IDLE=000, FETCH=001, DECODE=010, EXECUTE=011, WRITEBACK=100. Unused codes go to IDLE next cycle.
- IDLE:
  - Go to FETCH if run_mode=1, or if step_pulse=1 with run_mode=0.
  - Otherwise stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_valid: IR<=imem_data, pc<=pc+1 (wraps modulo 2^PC_W), go to DECODE.
  - Counter increments each cycle without valid. When it reaches FETCH_TIMEOUT: fetch_err pulse, pc unchanged, go to IDLE.
  - Counter clears on leaving FETCH.
- DECODE (by IR[15:14]):
  - 10 (ALU): br_sel_a=IR[5:3], br_sel_b=IR[2:0], ula_op=IR[10:6].
  - 01 (format I): ext_ctrl=00, ext_const=IR[10:0], br_sel_a=IR[13:11].
  - 11 (format II): ext_ctrl = IR[10] ? 10 : 01, ext_const={3'b0, IR[7:0]}, br_sel_a=IR[13:11].
  - Format I and II both set ula_op=ULA_OP_PASSB.
  - 00: illegal pulse, go to IDLE (no write).
  - Legal classes go to EXECUTE.
- EXECUTE: mux_ula_sel = (class==10) ? 0 : 1. Always go to WRITEBACK.
- WRITEBACK:
  - br_we=1 for exactly this cycle, with selects stable.
  - Then go to FETCH if run_mode=1, else to IDLE.
- Registered decode outputs hold from DECODE until the next DECODE.
- br_we is 0 in every state other than WRITEBACK.
- Edge cases:
  - botao edges outside IDLE are ignored. No queueing.
  - Dropping run_mode mid-instruction completes the current instruction, then parks in IDLE.
  - imem_valid outside FETCH is ignored.
  - reset mid-instruction: immediate return to reset values, and no br_we glitch (br_we is a registered output).
- Latency: 4 cycles per legal instruction plus memory wait cycles.

Decomposition:
- Package controle_pkg holds:
  - state enum;
  - instruction class constants CLS_ALU=2'b10, CLS_I=2'b01, CLS_II=2'b11;
  - extender codes;
  - ULA_OP_PASSB=5'b11111.
- Sub-module sincroniza_botao: 2-flop synchroniser plus rising-edge pulse, reset to 0.

Test Plan:
- Reset then run_mode=1, memory returns 16'h8053 (ALU) in the same cycle as the request:
  - DECODE shows br_sel_a=2, br_sel_b=3, ula_op=5'b00001;
  - br_we high exactly 1 cycle, 4 cycles after the fetch request;
  - pc=1.
- Format II 16'hC4A5 (IR[10]=1):
  - ext_ctrl=10, ext_const=11'h0A5, mux_ula_sel=1 in EXECUTE, br_sel_a=0.
- Illegal 16'h0000:
  - illegal pulses once, no br_we, state returns to IDLE, pc incremented by 1.
- imem_valid held low:
  - fetch_err pulses after 15 wait cycles, pc unchanged, state IDLE.
- run_mode=0, three botao bounces inside one IDLE window after synchronisation:
  - only the first edge starts an instruction;
  - a press during EXECUTE is ignored;
  - FSM parks in IDLE after WRITEBACK.
- pc=8'hFF fetch accepted:
  - pc wraps to 0.
- reset asserted during WRITEBACK:
  - br_we and all outputs 0 asynchronously; estado=000.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// classes, extender modes and the ULA pass-through opcode.
package controle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_FETCH     = 3'b001,
        ST_DECODE    = 3'b010,
        ST_EXECUTE   = 3'b011,
        ST_WRITEBACK = 3'b100
    } estado_t;

    // Instruction class lives in IR[15:14]; 2'b00 is not a valid class.
    localparam logic [1:0] CLS_ILLEGAL = 2'b00;
    localparam logic [1:0] CLS_I       = 2'b01;
    localparam logic [1:0] CLS_ALU     = 2'b10;
    localparam logic [1:0] CLS_II      = 2'b11;

    // Extender modes: 11-bit constant, load-constant-low, load-constant-high.
    localparam logic [1:0] EXT_CONST11 = 2'b00;
    localparam logic [1:0] EXT_LCL     = 2'b01;
    localparam logic [1:0] EXT_LCH     = 2'b10;

    // ULA operand B source.
    localparam logic MUX_SEL_BR  = 1'b0;
    localparam logic MUX_SEL_EXT = 1'b1;

    // ULA forwards operand B unchanged (used by the immediate formats).
    localparam logic [4:0] ULA_OP_PASSB = 5'b11111;

endpackage

// File: rtl/sincroniza_botao.sv
// Brings the asynchronous step button into the clock domain through two
// flops and turns each synchronised rising edge into a one-cycle pulse.
module sincroniza_botao (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic step_pulse
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    // Shift the button through the synchroniser and remember the last level.
    always_comb begin
        sync_d = {sync_q[0], botao};
        prev_d = sync_q[1];
    end

    // Synchroniser and edge-detect registers, cleared by the active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign step_pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: owns PC and IR, fetches from instruction memory,
// decodes the three instruction classes and sequences the register-bank write.
//
// Fetch handshake: imem_req is high for every FETCH cycle with imem_addr = pc;
// the memory answers by raising imem_valid with imem_data in some cycle while
// imem_req is high, and the word is captured on that clock edge. imem_valid
// seen while imem_req is low is ignored. If no answer arrives within
// FETCH_TIMEOUT request cycles the fetch is abandoned and fetch_err pulses.
//
// Every control output is a flop (or a decode of the state flop), so an
// asynchronous reset drops them all at once without glitching br_we.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int PC_W          = 8,
    parameter int REG_W         = 3,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_mode,
    input  logic             botao,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [15:0]      imem_data,
    output logic             br_we,
    output logic [REG_W-1:0] br_sel_a,
    output logic [REG_W-1:0] br_sel_b,
    output logic [1:0]       ext_ctrl,
    output logic [10:0]      ext_const,
    output logic             mux_ula_sel,
    output logic [4:0]       ula_op,
    output logic [2:0]       estado,
    output logic             illegal,
    output logic             fetch_err
);

    localparam int              CNT_W        = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    estado_t            state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [15:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_we_q, br_we_d;
    logic [REG_W-1:0]   sel_a_q, sel_a_d;
    logic [REG_W-1:0]   sel_b_q, sel_b_d;
    logic [1:0]         ext_ctrl_q, ext_ctrl_d;
    logic [10:0]        ext_const_q, ext_const_d;
    logic               mux_q, mux_d;
    logic [4:0]         ula_op_q, ula_op_d;
    logic               illegal_q, illegal_d;
    logic               fetch_err_q, fetch_err_d;
    logic               step_pulse;

    sincroniza_botao u_sincroniza_botao (
        .clock      (clock),
        .reset      (reset),
        .botao      (botao),
        .step_pulse (step_pulse)
    );

    // Next-state, PC/IR update and decode of the registered control fields.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        cnt_d       = '0;
        br_we_d     = 1'b0;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        ext_ctrl_d  = ext_ctrl_q;
        ext_const_d = ext_const_q;
        mux_d       = mux_q;
        ula_op_d    = ula_op_q;
        illegal_d   = 1'b0;
        fetch_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Step presses only count here; anywhere else they are dropped.
                if (run_mode || step_pulse) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Last allowed wait cycle expired: give up, keep pc.
                    fetch_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DECODE: begin
                // Fields not used by a class are zeroed so the datapath sees
                // a clean word; mux_ula_sel is chosen here so it is already
                // stable for the whole EXECUTE cycle.
                case (ir_q[15:14])
                    CLS_ALU: begin
                        sel_a_d     = REG_W'(ir_q[5:3]);
                        sel_b_d     = REG_W'(ir_q[2:0]);
                        ula_op_d    = ir_q[10:6];
                        ext_ctrl_d  = EXT_CONST11;
                        ext_const_d = '0;
                        mux_d       = MUX_SEL_BR;
                        state_d     = ST_EXECUTE;
                    end
                    CLS_I: begin
                        sel_a_d     = REG_W'(ir_q[13:11]);
                        sel_b_d     = '0;
                        ula_op_d    = ULA_OP_PASSB;
                        ext_ctrl_d  = EXT_CONST11;
                        ext_const_d = ir_q[10:0];
                        mux_d       = MUX_SEL_EXT;
                        state_d     = ST_EXECUTE;
                    end
                    CLS_II: begin
                        sel_a_d     = REG_W'(ir_q[13:11]);
                        sel_b_d     = '0;
                        ula_op_d    = ULA_OP_PASSB;
                        ext_ctrl_d  = ir_q[10] ? EXT_LCH : EXT_LCL;
                        ext_const_d = {3'b000, ir_q[7:0]};
                        mux_d       = MUX_SEL_EXT;
                        state_d     = ST_EXECUTE;
                    end
                    default: begin
                        // Class 00: flag it and abandon the instruction.
                        illegal_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                endcase
            end

            ST_EXECUTE: begin
                // Raise the write enable for exactly the WRITEBACK cycle.
                br_we_d = 1'b1;
                state_d = ST_WRITEBACK;
            end

            ST_WRITEBACK: begin
                state_d = run_mode ? ST_FETCH : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, program state and registered control outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            cnt_q       <= '0;
            br_we_q     <= 1'b0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            ext_ctrl_q  <= '0;
            ext_const_q <= '0;
            mux_q       <= 1'b0;
            ula_op_q    <= '0;
            illegal_q   <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            br_we_q     <= br_we_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            ext_ctrl_q  <= ext_ctrl_d;
            ext_const_q <= ext_const_d;
            mux_q       <= mux_d;
            ula_op_q    <= ula_op_d;
            illegal_q   <= illegal_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign br_we       = br_we_q;
    assign br_sel_a    = sel_a_q;
    assign br_sel_b    = sel_b_q;
    assign ext_ctrl    = ext_ctrl_q;
    assign ext_const   = ext_const_q;
    assign mux_ula_sel = mux_q;
    assign ula_op      = ula_op_q;
    assign estado      = state_q;
    assign illegal     = illegal_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: decode of each instruction class,
// write-enable timing, illegal and timeout paths, step button filtering,
// pc wrap and asynchronous reset during WRITEBACK.
module tb_controle_multiciclo;
    import controle_pkg::*;

    logic        clock;
    logic        reset;
    logic        run_mode;
    logic        botao;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        br_we;
    logic [2:0]  br_sel_a;
    logic [2:0]  br_sel_b;
    logic [1:0]  ext_ctrl;
    logic [10:0] ext_const;
    logic        mux_ula_sel;
    logic [4:0]  ula_op;
    logic [2:0]  estado;
    logic        illegal;
    logic        fetch_err;

    int          checks = 0;
    int          errors = 0;
    int          illegal_seen = 0;
    logic [7:0]  exp_pc;
    logic [10:0] exp_q[$];
    logic [2:0]  est_log [10];
    logic [2:0]  exp_est [10];

    controle_multiciclo #(
        .PC_W          (8),
        .REG_W         (3),
        .FETCH_TIMEOUT (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run_mode    (run_mode),
        .botao       (botao),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .br_we       (br_we),
        .br_sel_a    (br_sel_a),
        .br_sel_b    (br_sel_b),
        .ext_ctrl    (ext_ctrl),
        .ext_const   (ext_const),
        .mux_ula_sel (mux_ula_sel),
        .ula_op      (ula_op),
        .estado      (estado),
        .illegal     (illegal),
        .fetch_err   (fetch_err)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write-enable cycle must match the next expected
    // {br_sel_a, br_sel_b, ula_op}; also counts illegal pulses.
    always @(negedge clock) begin
        if (reset) begin
            if (br_we) begin
                if (exp_q.size() == 0) begin
                    check_eq("we_unexpected", br_we, 0);
                end else begin
                    check_eq("we_sig", {br_sel_a, br_sel_b, ula_op}, exp_q.pop_front());
                end
            end
            if (illegal) illegal_seen++;
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From IDLE, request exactly one fetch by holding run_mode for one edge.
    task automatic start_fetch();
        run_mode = 1'b1;
        tick();
        run_mode = 1'b0;
    endtask

    task automatic exec_instr(input logic [15:0] instr, input logic [2:0] e_a, input logic [2:0] e_b,
                              input logic [4:0] e_op, input logic [1:0] e_ext, input logic [10:0] e_const,
                              input logic e_mux);
        imem_valid = 1'b1;
        imem_data  = instr;
        start_fetch();
        check_eq("fetch_state", estado, ST_FETCH);
        check_eq("fetch_req", imem_req, 1);
        check_eq("fetch_addr", imem_addr, exp_pc);
        check_eq("fetch_we", br_we, 0);
        tick();
        exp_pc = exp_pc + 8'd1;
        check_eq("dec_state", estado, ST_DECODE);
        check_eq("dec_pc", imem_addr, exp_pc);
        check_eq("dec_we", br_we, 0);
        tick();
        check_eq("ex_state", estado, ST_EXECUTE);
        check_eq("ex_sel_a", br_sel_a, e_a);
        check_eq("ex_ula_op", ula_op, e_op);
        check_eq("ex_mux", mux_ula_sel, e_mux);
        check_eq("ex_we", br_we, 0);
        if (instr[15:14] == CLS_ALU) begin
            check_eq("ex_sel_b", br_sel_b, e_b);
        end else begin
            check_eq("ex_ext_ctrl", ext_ctrl, e_ext);
            check_eq("ex_ext_const", ext_const, e_const);
        end
        exp_q.push_back({e_a, e_b, e_op});
        tick();
        check_eq("wb_state", estado, ST_WRITEBACK);
        check_eq("wb_we", br_we, 1);
        check_eq("wb_sel_a", br_sel_a, e_a);
        tick();
        check_eq("park_state", estado, ST_IDLE);
        check_eq("park_we", br_we, 0);
    endtask

    // Apply a per-cycle botao pattern (bit i in cycle i) and log the state.
    task automatic drive_botao(input logic [9:0] pat);
        for (int i = 0; i < 10; i++) begin
            botao = pat[i];
            tick();
            est_log[i] = estado;
        end
        botao = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        run_mode   = 1'b0;
        botao      = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        exp_pc     = 8'h00;
        exp_est    = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};

        // Reset values.
        repeat (3) tick();
        check_eq("rst_state", estado, ST_IDLE);
        check_eq("rst_pc", imem_addr, 0);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_we", br_we, 0);
        check_eq("rst_outs", {br_sel_a, br_sel_b, ext_ctrl, ext_const, mux_ula_sel, ula_op, illegal, fetch_err}, 0);
        reset = 1'b1;
        tick();
        check_eq("idle_hold", estado, ST_IDLE);

        // ALU 8053: a=2, b=3, op=1, operand B from the bank.
        exec_instr(16'h8053, 3'd2, 3'd3, 5'b00001, 2'b00, 11'h000, 1'b0);
        check_eq("alu_pc", imem_addr, 8'd1);
        // Format II, IR[10]=1 -> lch; const = IR[7:0].
        exec_instr(16'hC4A5, 3'd0, 3'd0, ULA_OP_PASSB, EXT_LCH, 11'h0A5, 1'b1);
        // Format I: a=IR[13:11]=1, const = IR[10:0].
        exec_instr(16'h4BCD, 3'd1, 3'd0, ULA_OP_PASSB, EXT_CONST11, 11'h3CD, 1'b1);
        // Format II, IR[10]=0 -> lcl; a=3.
        exec_instr(16'hD87F, 3'd3, 3'd0, ULA_OP_PASSB, EXT_LCL, 11'h07F, 1'b1);

        // Illegal class 00: pulse once, back to IDLE, pc advanced, no write.
        imem_valid = 1'b1;
        imem_data  = 16'h0000;
        start_fetch();
        tick();
        exp_pc = exp_pc + 8'd1;
        tick();
        check_eq("ill_pulse", illegal, 1);
        check_eq("ill_state", estado, ST_IDLE);
        check_eq("ill_pc", imem_addr, exp_pc);
        tick();
        check_eq("ill_clear", illegal, 0);
        check_eq("ill_count", illegal_seen, 1);

        // Fetch timeout: 15 request cycles without valid.
        imem_valid = 1'b0;
        start_fetch();
        repeat (14) tick();
        check_eq("to_waiting", estado, ST_FETCH);
        check_eq("to_no_err", fetch_err, 0);
        tick();
        check_eq("to_err", fetch_err, 1);
        check_eq("to_state", estado, ST_IDLE);
        check_eq("to_pc", imem_addr, exp_pc);
        tick();
        check_eq("to_clear", fetch_err, 0);

        // Step mode, bouncing button: pulses land in IDLE, DECODE, WRITEBACK.
        imem_valid = 1'b1;
        imem_data  = 16'h8053;
        exp_q.push_back({3'd2, 3'd3, 5'b00001});
        drive_botao(10'b00_0001_0101);
        for (int i = 0; i < 10; i++) check_eq($sformatf("bounce_st%0d", i), est_log[i], exp_est[i]);
        exp_pc = exp_pc + 8'd1;
        // Second press timed so its pulse falls in EXECUTE.
        exp_q.push_back({3'd2, 3'd3, 5'b00001});
        drive_botao(10'b00_0000_1001);
        for (int i = 0; i < 10; i++) check_eq($sformatf("exec_press_st%0d", i), est_log[i], exp_est[i]);
        exp_pc = exp_pc + 8'd1;
        check_eq("step_pc", imem_addr, exp_pc);

        // Walk pc to FF with free-running illegal words (3 cycles each).
        begin
            int n;
            n = 255 - int'(exp_pc);
            imem_data = 16'h0000;
            run_mode  = 1'b1;
            repeat (3 * n) tick();
            run_mode  = 1'b0;
            tick();
            exp_pc = 8'hFF;
            check_eq("walk_pc", imem_addr, exp_pc);
            check_eq("walk_state", estado, ST_IDLE);
            check_eq("walk_ill_count", illegal_seen, 1 + n);
        end
        exec_instr(16'h8053, 3'd2, 3'd3, 5'b00001, 2'b00, 11'h000, 1'b0);
        check_eq("wrap_pc", imem_addr, 8'h00);

        // Free run back-to-back, then reset during the second WRITEBACK.
        imem_data = 16'h8053;
        run_mode  = 1'b1;
        tick();
        tick();
        tick();
        exp_q.push_back({3'd2, 3'd3, 5'b00001});
        tick();
        check_eq("fr_wb1", br_we, 1);
        tick();
        check_eq("fr_refetch", estado, ST_FETCH);
        check_eq("fr_addr", imem_addr, 8'h01);
        tick();
        tick();
        tick();
        check_eq("fr_wb2_state", estado, ST_WRITEBACK);
        check_eq("fr_wb2_we", br_we, 1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("arst_we", br_we, 0);
        check_eq("arst_state", estado, ST_IDLE);
        check_eq("arst_pc", imem_addr, 0);
        check_eq("arst_req", imem_req, 0);
        check_eq("arst_outs", {br_sel_a, br_sel_b, ext_ctrl, ext_const, mux_ula_sel, ula_op, illegal, fetch_err}, 0);
        run_mode = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_eq("post_rst_state", estado, ST_IDLE);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
